// File: rtl/adder_sum_accumulator.sv
// Accumulates BURST_LEN {carry,sum} beats from the adder result stream into a
// saturating running total, presented on a held valid/ready output.
module adder_sum_accumulator #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ACC_W     = 16,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [DATA_W-1:0]                    in_sum,
    input  logic                                 in_carry,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [ACC_W-1:0]                     out_total,
    output logic                                 out_ovf,
    output logic [$clog2(BURST_LEN+1)-1:0]       beat_cnt
);

    localparam int unsigned CNT_W  = $clog2(BURST_LEN + 1);
    localparam int unsigned BEAT_W = DATA_W + 1;
    localparam int unsigned SUM_W  = ACC_W + 1;

    typedef enum logic {
        ST_ACC   = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_total_q, out_total_d;
    logic               out_ovf_q, out_ovf_d;

    logic [BEAT_W-1:0]  beat;
    logic [SUM_W-1:0]   sum_ext;
    logic [ACC_W-1:0]   acc_sat;
    logic               sat_hit;
    logic               accept;
    logic               last_beat;

    // Ready depends only on state; held low throughout reset.
    assign in_ready  = (state_q == ST_ACC) && !rst;
    assign accept    = in_valid && in_ready;
    assign last_beat = (cnt_q == CNT_W'(BURST_LEN - 1));

    // Saturating add of the zero-extended beat onto the running sum.
    always_comb begin
        beat    = {in_carry, in_sum};
        sum_ext = SUM_W'(acc_q) + SUM_W'(beat);
        sat_hit = sum_ext[ACC_W];
        acc_sat = sat_hit ? '1 : sum_ext[ACC_W-1:0];
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_total_d = out_total_q;
        out_ovf_d   = out_ovf_q;

        case (state_q)
            ST_ACC: begin
                if (accept) begin
                    acc_d = acc_sat;
                    ovf_d = ovf_q | sat_hit;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_beat) begin
                        out_total_d = acc_sat;
                        out_ovf_d   = ovf_q | sat_hit;
                        out_valid_d = 1'b1;
                        state_d     = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Total stays frozen until taken; burst state clears on handoff.
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                    state_d     = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_total_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_total_q <= out_total_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_total = out_total_q;
    assign out_ovf   = out_ovf_q;
    assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Drives three accumulator configurations from one shared stream and checks each
// against a burst-level arithmetic model.
module tb_adder_sum_accumulator;

    localparam int NDUT = 3;
    localparam int ACCW [NDUT] = '{16, 10, 16};
    localparam int BL   [NDUT] = '{4, 4, 1};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_sum = 8'h00;
    logic       in_carry = 1'b0;
    logic       out_ready = 1'b0;

    logic        ir [NDUT];
    logic        ov [NDUT];
    logic        oo [NDUT];
    logic [15:0] ot [NDUT];
    logic [2:0]  bc [NDUT];

    logic [15:0] tot0;
    logic [9:0]  tot1;
    logic [15:0] tot2;
    logic [2:0]  bc0;
    logic [2:0]  bc1;
    logic [0:0]  bc2;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state per configuration
    int m_sum   [NDUT];
    int m_cnt   [NDUT];
    bit m_drain [NDUT];
    bit m_valid [NDUT];
    bit m_ovf   [NDUT];
    int m_total [NDUT];

    always #5 clk = ~clk;

    adder_sum_accumulator #(.DATA_W(8), .ACC_W(16), .BURST_LEN(4)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
        .in_sum(in_sum), .in_carry(in_carry), .out_valid(ov[0]), .out_ready(out_ready),
        .out_total(tot0), .out_ovf(oo[0]), .beat_cnt(bc0)
    );
    adder_sum_accumulator #(.DATA_W(8), .ACC_W(10), .BURST_LEN(4)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
        .in_sum(in_sum), .in_carry(in_carry), .out_valid(ov[1]), .out_ready(out_ready),
        .out_total(tot1), .out_ovf(oo[1]), .beat_cnt(bc1)
    );
    adder_sum_accumulator #(.DATA_W(8), .ACC_W(16), .BURST_LEN(1)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
        .in_sum(in_sum), .in_carry(in_carry), .out_valid(ov[2]), .out_ready(out_ready),
        .out_total(tot2), .out_ovf(oo[2]), .beat_cnt(bc2)
    );

    assign ot[0] = tot0;
    assign ot[1] = 16'(tot1);
    assign ot[2] = tot2;
    assign bc[0] = bc0;
    assign bc[1] = bc1;
    assign bc[2] = 3'(bc2);

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            m_sum[k] = 0; m_cnt[k] = 0; m_drain[k] = 0;
            m_valid[k] = 0; m_ovf[k] = 0; m_total[k] = 0;
        end
    end

    // Burst-level model: exact sum, clamped at presentation time.
    always @(posedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            int maxv;
            maxv = (1 << ACCW[k]) - 1;
            if (rst) begin
                m_sum[k] = 0; m_cnt[k] = 0; m_drain[k] = 0;
                m_valid[k] = 0; m_ovf[k] = 0; m_total[k] = 0;
            end else if (!m_drain[k]) begin
                if (in_valid) begin
                    m_sum[k] = m_sum[k] + int'({in_carry, in_sum});
                    m_cnt[k] = m_cnt[k] + 1;
                    if (m_cnt[k] == BL[k]) begin
                        m_total[k] = (m_sum[k] > maxv) ? maxv : m_sum[k];
                        m_ovf[k]   = (m_sum[k] > maxv);
                        m_valid[k] = 1;
                        m_drain[k] = 1;
                    end
                end
            end else if (out_ready) begin
                m_valid[k] = 0; m_drain[k] = 0; m_sum[k] = 0; m_cnt[k] = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("dut%0d in_ready", k),  32'(ir[k]), 32'(!rst && !m_drain[k]));
            chk($sformatf("dut%0d out_valid", k), 32'(ov[k]), 32'(m_valid[k]));
            chk($sformatf("dut%0d out_total", k), 32'(ot[k]), 32'(m_total[k]));
            chk($sformatf("dut%0d out_ovf", k),   32'(oo[k]), 32'(m_ovf[k]));
            chk($sformatf("dut%0d beat_cnt", k),  32'(bc[k]), 32'(m_cnt[k]));
        end
    endtask

    // Apply inputs for one cycle, then check outputs mid-cycle.
    task automatic step(input logic v, input logic [8:0] val, input logic r, input logic rs);
        in_valid = v;
        {in_carry, in_sum} = val;
        out_ready = r;
        rst = rs;
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [8:0] beats [4];

        // Reset behaviour
        step(1'b0, 9'h000, 1'b0, 1'b1);
        step(1'b0, 9'h000, 1'b0, 1'b1);
        chk("rst in_ready", 32'(ir[0]), 32'd0);
        chk("rst out_valid", 32'(ov[0]), 32'd0);
        chk("rst out_total", 32'(tot0), 32'd0);
        chk("rst beat_cnt", 32'(bc0), 32'd0);
        step(1'b0, 9'h000, 1'b0, 1'b0);
        chk("post-rst in_ready", 32'(ir[0]), 32'd1);

        // Back-to-back burst
        beats = '{9'h010, 9'h020, 9'h030, 9'h040};
        foreach (beats[i]) step(1'b1, beats[i], 1'b0, 1'b0);
        chk("b2b out_valid", 32'(ov[0]), 32'd1);
        chk("b2b out_total", 32'(tot0), 32'h00A0);
        chk("b2b out_ovf", 32'(oo[0]), 32'd0);

        // Held total under backpressure with input still offered
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 9'h077, 1'b0, 1'b0);
            chk("hold out_total", 32'(tot0), 32'h00A0);
            chk("hold in_ready", 32'(ir[0]), 32'd0);
            chk("hold beat_cnt", 32'(bc0), 32'd4);
        end
        step(1'b0, 9'h000, 1'b1, 1'b0);
        chk("drain in_ready", 32'(ir[0]), 32'd1);
        chk("drain out_valid", 32'(ov[0]), 32'd0);

        // Gapped burst of 0x1FF beats; saturates the narrow accumulator
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 9'h1FF, 1'b0, 1'b0);
            if (i < 3) begin
                chk("gap beat_cnt", 32'(bc0), 32'(i + 1));
                for (int g = 0; g < 3; g++) step(1'b0, 9'h1FF, 1'b0, 1'b0);
            end
        end
        chk("gap out_total", 32'(tot0), 32'h07FC);
        chk("gap out_ovf", 32'(oo[0]), 32'd0);
        chk("sat out_total", 32'(tot1), 32'h03FF);
        chk("sat out_ovf", 32'(oo[1]), 32'd1);
        step(1'b0, 9'h000, 1'b1, 1'b0);

        for (int i = 0; i < 4; i++) step(1'b1, 9'h001, 1'b0, 1'b0);
        chk("post-sat out_total", 32'(tot1), 32'h0004);
        chk("post-sat out_ovf", 32'(oo[1]), 32'd0);
        step(1'b0, 9'h000, 1'b1, 1'b0);

        // Reset mid-burst discards partial sum
        step(1'b1, 9'h050, 1'b0, 1'b0);
        step(1'b1, 9'h050, 1'b0, 1'b0);
        step(1'b0, 9'h000, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 9'h001, 1'b0, 1'b0);
        chk("midrst out_total", 32'(tot0), 32'h0004);
        step(1'b0, 9'h000, 1'b1, 1'b0);

        // Single-beat bursts
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 9'h1AB, 1'b0, 1'b0);
            chk("bl1 out_total", 32'(tot2), 32'h01AB);
            chk("bl1 out_valid", 32'(ov[2]), 32'd1);
            step(1'b0, 9'h000, 1'b1, 1'b0);
        end

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            logic [8:0] val;
            val = ($urandom_range(0, 3) == 0) ? 9'h1FF : 9'($urandom);
            step($urandom_range(0, 3) != 0, val, 1'($urandom), $urandom_range(0, 99) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
